// File: rtl/pooling_output_interface_pkg.sv
// Shared pooling parameters: scalar width, kernel size, pooled row length and
// block-tag width, plus the counter-width helper used by the collectors.
package pooling_output_interface_pkg;

  localparam int POOL_DATA_WIDTH = 32;
  localparam int POOL_KERNEL_SIZE = 2;
  localparam int POOL_PACK_SIZE = 3;
  localparam int POOL_IDX_WIDTH = 3;

  // Narrowest counter able to hold 0..n-1; never zero bits wide.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pooling_output_interface.sv
// Serial-to-parallel collector: packs PACK_SIZE pooled scalars into one row
// word (first word in the MSBs) and tags it with the block index of word 0.
module pooling_output_interface
  import pooling_output_interface_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int PACK_SIZE  = POOL_PACK_SIZE,
  parameter int IDX_WIDTH  = POOL_IDX_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            input_valid,
  output logic                            input_ready,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [IDX_WIDTH-1:0]            block_idx,
  input  logic                            flush,
  output logic                            output_valid,
  input  logic                            output_ready,
  output logic [PACK_SIZE*DATA_WIDTH-1:0] data_out,
  output logic [IDX_WIDTH-1:0]            block_idx_out
);

  // Handshake: a transfer happens on a clk edge where valid && ready are both
  // high; a producer holds valid and its payload stable until that edge.

  localparam int CNT_W = cnt_width(PACK_SIZE);
  localparam int BUF_N = (PACK_SIZE > 1) ? PACK_SIZE - 1 : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK_SIZE - 1);

  logic [CNT_W-1:0]                word_cnt;
  logic [DATA_WIDTH-1:0]           buf_q [BUF_N];
  logic [IDX_WIDTH-1:0]            tag_q;
  logic                            accept;
  logic                            slot_free;
  logic                            emit;
  logic [PACK_SIZE*DATA_WIDTH-1:0] row;
  logic [IDX_WIDTH-1:0]            row_tag;

  // Only the completing word waits on a blocked output slot.
  assign input_ready = (word_cnt != LAST) || !output_valid || output_ready;
  assign accept      = input_valid && input_ready;
  assign slot_free   = !output_valid || output_ready;
  assign emit        = (accept && (word_cnt == LAST)) ||
                       (flush && slot_free && (accept || (word_cnt != '0)));

  // Row image as it would look if emitted now; slots past the last word are zero.
  always_comb begin
    row     = '0;
    row_tag = tag_q;
    for (int j = 0; j < PACK_SIZE - 1; j++) begin
      if (j < int'(word_cnt))
        row[(PACK_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = buf_q[j];
      else if (accept && (j == int'(word_cnt)))
        row[(PACK_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] = data_in;
    end
    if (accept && (word_cnt == LAST))
      row[DATA_WIDTH-1:0] = data_in;
    if (accept && (word_cnt == '0))
      row_tag = block_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt      <= '0;
      tag_q         <= '0;
      output_valid  <= 1'b0;
      data_out      <= '0;
      block_idx_out <= '0;
      for (int j = 0; j < BUF_N; j++) buf_q[j] <= '0;
    end else begin
      if (emit) begin
        word_cnt      <= '0;
        data_out      <= row;
        block_idx_out <= row_tag;
        output_valid  <= 1'b1;
      end else begin
        if (output_ready) output_valid <= 1'b0;
        if (accept) begin
          buf_q[word_cnt] <= data_in;
          word_cnt        <= word_cnt + 1'b1;
          if (word_cnt == '0) tag_q <= block_idx;
        end
      end
    end
  end

`ifdef DEBUG
  shortreal dbg_slot [PACK_SIZE];
  always_comb begin
    for (int j = 0; j < PACK_SIZE; j++)
      dbg_slot[j] = $bitstoshortreal(data_out[(PACK_SIZE-1-j)*DATA_WIDTH +: 32]);
  end
`endif

endmodule

// File: tb/tb_pooling_output_interface.sv
// Directed bench for pooling_output_interface: per-cycle vector table plus a
// reset-mid-row sequence checked through an expected-row queue.
module tb_pooling_output_interface;

  localparam int DW = 32;
  localparam int PS = 3;
  localparam int IW = 3;
  localparam int RW = PS * DW;

  localparam logic [31:0] F0 = 32'h0000_0000;
  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;
  localparam logic [31:0] F6 = 32'h40C0_0000;
  localparam logic [31:0] F7 = 32'h40E0_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          input_valid = 1'b0;
  logic          input_ready;
  logic [DW-1:0] data_in = '0;
  logic [IW-1:0] block_idx = '0;
  logic          flush = 1'b0;
  logic          output_valid;
  logic          output_ready = 1'b1;
  logic [RW-1:0] data_out;
  logic [IW-1:0] block_idx_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [IW-1:0] idx;
    logic          f;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [RW-1:0] exp_data;
    logic [IW-1:0] exp_idx;
  } vec_t;

  vec_t vecs[$];
  logic [RW+IW-1:0] exp_q[$];
  logic mon_en = 1'b0;

  pooling_output_interface dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready),
    .data_in(data_in), .block_idx(block_idx), .flush(flush),
    .output_valid(output_valid), .output_ready(output_ready),
    .data_out(data_out), .block_idx_out(block_idx_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && output_valid && output_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got row %h idx %0d expected none", data_out, block_idx_out);
      end else begin
        logic [RW+IW-1:0] e;
        e = exp_q.pop_front();
        if ({data_out, block_idx_out} !== e) begin
          failures++;
          $display("FAIL sb_row: got %h expected %h", {data_out, block_idx_out}, e);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic add(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] idx,
                     input logic f, input logic ordy, input logic ir, input logic ov,
                     input logic [RW-1:0] ed, input logic [IW-1:0] ei);
    vec_t t;
    t.v = v; t.d = d; t.idx = idx; t.f = f; t.ordy = ordy;
    t.exp_ir = ir; t.exp_ov = ov; t.exp_data = ed; t.exp_idx = ei;
    vecs.push_back(t);
  endtask

  // Drive for one cycle; leaves time at posedge+1.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [IW-1:0] idx,
                       input logic f, input logic ordy);
    input_valid = v; data_in = d; block_idx = idx; flush = f; output_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ir, ov, data, idx are expectations for the cycle (ir) and after its edge
    add(1, F1, 5, 0, 1, 1, 0, {F0, F0, F0}, 0);
    add(1, F2, 2, 0, 1, 1, 0, {F0, F0, F0}, 0);
    add(1, F3, 7, 0, 1, 1, 1, {F1, F2, F3}, 5);
    add(0, F0, 0, 0, 1, 1, 0, {F1, F2, F3}, 5);
    // row held under back-pressure, next row collects behind it
    add(1, F2, 3, 0, 0, 1, 0, {F1, F2, F3}, 5);
    add(1, F3, 0, 0, 0, 1, 0, {F1, F2, F3}, 5);
    add(1, F1, 0, 0, 0, 1, 1, {F2, F3, F1}, 3);
    add(1, F4, 4, 0, 0, 1, 1, {F2, F3, F1}, 3);
    add(1, F5, 0, 0, 0, 1, 1, {F2, F3, F1}, 3);
    add(1, F6, 0, 0, 0, 0, 1, {F2, F3, F1}, 3);
    add(1, F6, 0, 0, 1, 1, 1, {F4, F5, F6}, 4);
    add(0, F0, 0, 0, 1, 1, 0, {F4, F5, F6}, 4);
    // gapless stream of six words
    add(1, F1, 0, 0, 1, 1, 0, {F4, F5, F6}, 4);
    add(1, F2, 1, 0, 1, 1, 0, {F4, F5, F6}, 4);
    add(1, F3, 2, 0, 1, 1, 1, {F1, F2, F3}, 0);
    add(1, F4, 3, 0, 1, 1, 0, {F1, F2, F3}, 0);
    add(1, F5, 4, 0, 1, 1, 0, {F1, F2, F3}, 0);
    add(1, F6, 5, 0, 1, 1, 1, {F4, F5, F6}, 3);
    add(0, F0, 0, 0, 1, 1, 0, {F4, F5, F6}, 3);
    // flush alone, empty flush, flush with word
    add(1, F7, 6, 0, 1, 1, 0, {F4, F5, F6}, 3);
    add(0, F0, 0, 1, 1, 1, 1, {F7, F0, F0}, 6);
    add(0, F0, 0, 1, 1, 1, 0, {F7, F0, F0}, 6);
    add(1, F2, 1, 1, 1, 1, 1, {F2, F0, F0}, 1);
    add(0, F0, 0, 0, 1, 1, 0, {F2, F0, F0}, 1);
    // flush held off while the output slot is blocked
    add(1, F1, 2, 0, 0, 1, 0, {F2, F0, F0}, 1);
    add(1, F2, 0, 0, 0, 1, 0, {F2, F0, F0}, 1);
    add(1, F3, 0, 0, 0, 1, 1, {F1, F2, F3}, 2);
    add(1, F4, 5, 0, 0, 1, 1, {F1, F2, F3}, 2);
    add(0, F0, 0, 1, 0, 1, 1, {F1, F2, F3}, 2);
    add(0, F0, 0, 1, 1, 1, 1, {F4, F0, F0}, 5);
    add(0, F0, 0, 0, 1, 1, 0, {F4, F0, F0}, 5);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ov", 128'(output_valid), 128'(0));
    check("reset_data", 128'(data_out), 128'(0));
    check("reset_idx", 128'(block_idx_out), 128'(0));
    check("reset_ir", 128'(input_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      input_valid = vecs[i].v; data_in = vecs[i].d; block_idx = vecs[i].idx;
      flush = vecs[i].f; output_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_ir", i), 128'(input_ready), 128'(vecs[i].exp_ir));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ov", i), 128'(output_valid), 128'(vecs[i].exp_ov));
      check($sformatf("v%0d_data", i), 128'(data_out), 128'(vecs[i].exp_data));
      check($sformatf("v%0d_idx", i), 128'(block_idx_out), 128'(vecs[i].exp_idx));
    end

    // reset with a row held and a partial row collected
    drive(1, F1, 1, 0, 0);
    drive(1, F2, 0, 0, 0);
    drive(1, F3, 0, 0, 0);
    drive(1, F3, 6, 0, 0);
    drive(1, F4, 0, 0, 0);
    drive(0, F0, 0, 0, 0);
    check("pre_rst_ov", 128'(output_valid), 128'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_ov", 128'(output_valid), 128'(0));
    check("mid_rst_data", 128'(data_out), 128'(0));
    check("mid_rst_idx", 128'(block_idx_out), 128'(0));
    check("mid_rst_ir", 128'(input_ready), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    mon_en = 1'b1;
    exp_q.push_back({F5, F6, F7, 3'd4});
    drive(1, F5, 4, 0, 1);
    drive(1, F6, 1, 0, 1);
    drive(1, F7, 2, 0, 1);
    drive(0, F0, 0, 0, 1);
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) drive(0, F0, 0, 0, 1);
    check("sb_drain", 128'(exp_q.size()), 128'(0));
    check("post_rst_ov", 128'(output_valid), 128'(0));
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
